// File: rtl/muldiv_sequencer.sv
// Sequences MULT/DIV requests to the shared engines and commits results to HI/LO.
// MFHI/MFLO answer in 1 cycle, MULT/DIV in engine latency + 3; busy stalls the requester, which holds opValid until busy=0.
module muldiv_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             opValid,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  output logic             multControl,
  output logic             divControl,
  output logic [WIDTH-1:0] engA,
  output logic [WIDTH-1:0] engB,
  input  logic             multStop,
  input  logic             divStop,
  input  logic [WIDTH-1:0] multHi,
  input  logic [WIDTH-1:0] multLo,
  input  logic [WIDTH-1:0] divHi,
  input  logic [WIDTH-1:0] divLo,
  output logic [WIDTH-1:0] hiReg,
  output logic [WIDTH-1:0] loReg,
  output logic [WIDTH-1:0] readData,
  output logic             busy,
  output logic             opDone,
  output logic             divZero,
  output logic             engError
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MFHI = 2'b10;
  localparam logic [1:0] OP_MFLO = 2'b11;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [WIDTH-1:0]   hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, read_q, read_d;
  logic               op_done_q, op_done_d, div_zero_q, div_zero_d;
  logic               eng_error_q, eng_error_d;
  logic               stop_sel;

  // Only the launched engine's flag counts; the other may be stale-high.
  assign stop_sel = is_div_q ? divStop : multStop;

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    hold_hi_d   = hold_hi_q;
    hold_lo_d   = hold_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    read_d      = read_q;
    op_done_d   = 1'b0;
    div_zero_d  = 1'b0;
    eng_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (opValid) begin
          case (opCode)
            OP_MULT, OP_DIV: begin
              if (opCode == OP_DIV && rtData == '0) begin
                div_zero_d = 1'b1;
                op_done_d  = 1'b1;
              end else begin
                eng_a_d  = rsData;
                eng_b_d  = rtData;
                is_div_d = (opCode == OP_DIV);
                state_d  = S_LAUNCH;
              end
            end
            OP_MFHI: begin
              read_d    = hi_q;
              op_done_d = 1'b1;
            end
            OP_MFLO: begin
              read_d    = lo_q;
              op_done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop_sel) begin
          hold_hi_d = is_div_q ? divHi : multHi;
          hold_lo_d = is_div_q ? divLo : multLo;
          state_d   = S_COMMIT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          eng_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        hi_d      = hold_hi_q;
        lo_d      = hold_lo_q;
        op_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      hold_hi_q   <= '0;
      hold_lo_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      read_q      <= '0;
      op_done_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      eng_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      hold_hi_q   <= hold_hi_d;
      hold_lo_q   <= hold_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      read_q      <= read_d;
      op_done_q   <= op_done_d;
      div_zero_q  <= div_zero_d;
      eng_error_q <= eng_error_d;
    end
  end

  assign multControl = (state_q == S_LAUNCH) && !is_div_q;
  assign divControl  = (state_q == S_LAUNCH) && is_div_q;
  assign busy        = (state_q != S_IDLE);
  assign engA        = eng_a_q;
  assign engB        = eng_b_q;
  assign hiReg       = hi_q;
  assign loReg       = lo_q;
  assign readData    = read_q;
  assign opDone      = op_done_q;
  assign divZero     = div_zero_q;
  assign engError    = eng_error_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: engine stubs with 33-cycle latency, expectation queue and completion monitor.
module tb_muldiv_sequencer;
  localparam int W   = 32;
  localparam int TO  = 40;
  localparam int LAT = 33;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MFHI = 2'b10;
  localparam logic [1:0] OP_MFLO = 2'b11;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         opValid = 1'b0;
  logic [1:0]   opCode = 2'b00;
  logic [W-1:0] rsData = '0;
  logic [W-1:0] rtData = '0;
  logic         multControl, divControl, multStop, divStop;
  logic [W-1:0] engA, engB, multHi, multLo, divHi, divLo;
  logic [W-1:0] hiReg, loReg, readData;
  logic         busy, opDone, divZero, engError;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .opValid(opValid), .opCode(opCode),
    .rsData(rsData), .rtData(rtData),
    .multControl(multControl), .divControl(divControl),
    .engA(engA), .engB(engB),
    .multStop(multStop), .divStop(divStop),
    .multHi(multHi), .multLo(multLo), .divHi(divHi), .divLo(divLo),
    .hiReg(hiReg), .loReg(loReg), .readData(readData),
    .busy(busy), .opDone(opDone), .divZero(divZero), .engError(engError)
  );

  // Engine stubs: stop rises LAT edges after the start edge and stays high until the next start.
  logic m_run, m_stop, d_run, d_stop;
  int   m_cnt, d_cnt;
  logic hang = 1'b0;
  logic mult_stale = 1'b0;

  always @(posedge clk) begin
    if (Reset) begin
      m_run <= 1'b0; m_stop <= 1'b0; m_cnt <= 0;
    end else if (multControl) begin
      m_run <= 1'b1; m_stop <= 1'b0; m_cnt <= 1;
    end else if (m_run) begin
      if (m_cnt == LAT) begin
        m_stop <= !hang;
        m_run  <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (Reset) begin
      d_run <= 1'b0; d_stop <= 1'b0; d_cnt <= 0;
    end else if (divControl) begin
      d_run <= 1'b1; d_stop <= 1'b0; d_cnt <= 1;
    end else if (d_run) begin
      if (d_cnt == LAT) begin
        d_stop <= 1'b1;
        d_run  <= 1'b0;
      end else begin
        d_cnt <= d_cnt + 1;
      end
    end
  end

  logic signed [63:0] prod;
  assign prod     = $signed(engA) * $signed(engB);
  assign multHi   = prod[63:32];
  assign multLo   = prod[31:0];
  assign divLo    = (engB != '0) ? engA / engB : '0;
  assign divHi    = (engB != '0) ? engA % engB : '0;
  assign multStop = m_stop | mult_stale;
  assign divStop  = d_stop;

  int cyc = 0, mpulse = 0, dpulse = 0, busy_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (multControl) mpulse <= mpulse + 1;
    if (divControl)  dpulse <= dpulse + 1;
    if (busy)        busy_cyc <= busy_cyc + 1;
  end

  typedef struct {
    int           id;
    logic         done;
    logic         err;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int id, input logic done, input logic err, input logic dz,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] rd);
    exp_t e;
    e.id = id; e.done = done; e.err = err; e.dz = dz;
    e.hi = hi; e.lo = lo; e.rd = rd; e.due = 0;
    return e;
  endfunction

  // The completion (or error) must be visible lat cycles after the acceptance cycle.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input exp_t e, input int lat);
    @(negedge clk);
    if (push) begin
      e.due = cyc + 1 + lat;
      exp_q.push_back(e);
    end
    opValid = 1'b1; opCode = op; rsData = a; rtData = b;
    @(negedge clk);
    opValid = 1'b0;
  endtask

  initial begin
    int m0, d0, b0;

    fork
      begin : monitor
        exp_t m;
        forever begin
          @(negedge clk);
          if (!Reset && (opDone || engError)) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_completion: got opDone=%0b engError=%0b at cycle %0d, required none",
                       opDone, engError, cyc);
            end else begin
              m = exp_q.pop_front();
              chk($sformatf("v%0d_opDone", m.id),   opDone,   m.done);
              chk($sformatf("v%0d_engError", m.id), engError, m.err);
              chk($sformatf("v%0d_divZero", m.id),  divZero,  m.dz);
              chk($sformatf("v%0d_hiReg", m.id),    hiReg,    m.hi);
              chk($sformatf("v%0d_loReg", m.id),    loReg,    m.lo);
              chk($sformatf("v%0d_readData", m.id), readData, m.rd);
              chk($sformatf("v%0d_cycle", m.id),    cyc,      m.due);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_hilo", {hiReg, loReg}, 64'h0);
    chk("rst_readData", readData, 64'h0);
    chk("rst_eng", {engA, engB}, 64'h0);
    chk("rst_ctrl", {busy, opDone, multControl, divControl, divZero, engError}, 64'h0);
    Reset = 1'b0;

    // MFHI straight after reset
    b0 = busy_cyc;
    issue(OP_MFHI, '0, '0, 1'b1, mk(1, 1, 0, 0, '0, '0, '0), 0);
    repeat (4) @(negedge clk);
    chk("v1_busy_cycles", busy_cyc - b0, 64'd0);
    chk("v1_drained", exp_q.size(), 64'd0);

    // MULT 7 * -3
    m0 = mpulse; d0 = dpulse; b0 = busy_cyc;
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, mk(2, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, '0), LAT + 3);
    repeat (LAT + 8) @(negedge clk);
    chk("v2_mult_pulses", mpulse - m0, 64'd1);
    chk("v2_div_pulses", dpulse - d0, 64'd0);
    chk("v2_busy_cycles", busy_cyc - b0, 64'd36);
    chk("v2_drained", exp_q.size(), 64'd0);

    // DIV 17 / 5 with a stale multStop held high
    mult_stale = 1'b1;
    m0 = mpulse; d0 = dpulse;
    issue(OP_DIV, 32'd17, 32'd5, 1'b1, mk(3, 1, 0, 0, 32'd2, 32'd3, '0), LAT + 3);
    repeat (LAT + 8) @(negedge clk);
    mult_stale = 1'b0;
    chk("v3_mult_pulses", mpulse - m0, 64'd0);
    chk("v3_div_pulses", dpulse - d0, 64'd1);
    chk("v3_drained", exp_q.size(), 64'd0);

    // MULT while the mult stop flag is still high from the previous MULT
    issue(OP_MULT, 32'h0001_0001, 32'h0001_0000, 1'b1, mk(4, 1, 0, 0, 32'd1, 32'h0001_0000, '0), LAT + 3);
    repeat (LAT + 8) @(negedge clk);
    chk("v4_drained", exp_q.size(), 64'd0);

    // DIV by zero
    m0 = mpulse; d0 = dpulse; b0 = busy_cyc;
    issue(OP_DIV, 32'd9, 32'd0, 1'b1, mk(5, 1, 0, 1, 32'd1, 32'h0001_0000, '0), 0);
    repeat (4) @(negedge clk);
    chk("v5_start_pulses", (mpulse - m0) + (dpulse - d0), 64'd0);
    chk("v5_busy_cycles", busy_cyc - b0, 64'd0);
    chk("v5_drained", exp_q.size(), 64'd0);

    issue(OP_MFHI, '0, '0, 1'b1, mk(6, 1, 0, 0, 32'd1, 32'h0001_0000, 32'd1), 0);
    repeat (3) @(negedge clk);

    // Hung mult engine
    hang = 1'b1;
    issue(OP_MULT, 32'd3, 32'd4, 1'b1, mk(7, 0, 1, 0, 32'd1, 32'h0001_0000, 32'd1), TO + 1);
    repeat (TO + 6) @(negedge clk);
    hang = 1'b0;
    chk("v7_drained", exp_q.size(), 64'd0);

    issue(OP_MFLO, '0, '0, 1'b1, mk(8, 1, 0, 0, 32'd1, 32'h0001_0000, 32'h0001_0000), 0);
    repeat (3) @(negedge clk);
    chk("v8_drained", exp_q.size(), 64'd0);

    // Reset 10 cycles into WAIT, with a second request presented while busy
    m0 = mpulse; d0 = dpulse;
    issue(OP_MULT, 32'd5, 32'd6, 1'b0, mk(9, 0, 0, 0, '0, '0, '0), 0);
    @(negedge clk);
    opValid = 1'b1; opCode = OP_DIV; rsData = 32'd8; rtData = 32'd2;
    repeat (3) @(negedge clk);
    opValid = 1'b0;
    repeat (7) @(negedge clk);
    chk("v9_busy_before_reset", busy, 64'd1);
    Reset = 1'b1;
    @(negedge clk);
    chk("v9_hilo", {hiReg, loReg}, 64'h0);
    chk("v9_readData", readData, 64'h0);
    chk("v9_eng", {engA, engB}, 64'h0);
    chk("v9_ctrl", {busy, opDone, multControl, divControl, divZero, engError}, 64'h0);
    Reset = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    chk("v9_mult_pulses", mpulse - m0, 64'd1);
    chk("v9_div_pulses", dpulse - d0, 64'd0);
    chk("v9_busy_after", busy, 64'd0);
    chk("v9_hilo_after", {hiReg, loReg}, 64'h0);

    chk("queue_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
